// File: rtl/pipelined_adder_seg.sv
// Segment-pipelined WIDTH-bit adder/subtractor: one SW-bit ripple segment per stage, carry registered between stages.
// Optional signed-overflow output enabled by defining PIPE_ADD_OVF_EN.
module pipelined_adder_seg #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SW = WIDTH / SEGS;

    logic             vld_q [SEGS];
    logic             vld_d [SEGS];
    logic [WIDTH-1:0] opa_q [SEGS];
    logic [WIDTH-1:0] opa_d [SEGS];
    logic [WIDTH-1:0] opb_q [SEGS];
    logic [WIDTH-1:0] opb_d [SEGS];
    logic [WIDTH-1:0] sum_q [SEGS];
    logic [WIDTH-1:0] sum_d [SEGS];
    logic             cy_q  [SEGS];
    logic             cy_d  [SEGS];

    logic             stg_vld [SEGS];
    logic [WIDTH-1:0] stg_a   [SEGS];
    logic [WIDTH-1:0] stg_b   [SEGS];
    logic [WIDTH-1:0] stg_s   [SEGS];
    logic             stg_cy  [SEGS];
    logic [SW:0]      seg_c   [SEGS];

    logic adv_c;

    // Single global advance: the whole pipeline moves or the whole pipeline holds.
    assign adv_c    = !vld_q[SEGS-1] || out_ready;
    assign in_ready = adv_c;

    // Stage inputs: stage 0 takes the (inverted for subtract) operands, later stages take the previous register.
    always_comb begin : stage_inputs
        stg_vld[0] = in_valid;
        stg_a[0]   = a;
        stg_b[0]   = sub ? ~b : b;
        stg_s[0]   = '0;
        stg_cy[0]  = c_in ^ sub;
        for (int k = 1; k < int'(SEGS); k++) begin
            stg_vld[k] = vld_q[k-1];
            stg_a[k]   = opa_q[k-1];
            stg_b[k]   = opb_q[k-1];
            stg_s[k]   = sum_q[k-1];
            stg_cy[k]  = cy_q[k-1];
        end
    end

    // Each stage ripples its own SW-bit slice and forwards the remaining operands and finished sum bits.
    always_comb begin : seg_add
        for (int k = 0; k < int'(SEGS); k++) begin
            seg_c[k] = {1'b0, stg_a[k][k*SW +: SW]} + {1'b0, stg_b[k][k*SW +: SW]}
                     + (SW+1)'(stg_cy[k]);
            vld_d[k] = stg_vld[k];
            opa_d[k] = stg_a[k];
            opb_d[k] = stg_b[k];
            sum_d[k] = stg_s[k];
            sum_d[k][k*SW +: SW] = seg_c[k][SW-1:0];
            cy_d[k]  = seg_c[k][SW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(SEGS); k++) begin
                vld_q[k] <= 1'b0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
                cy_q[k]  <= 1'b0;
            end
        end else if (adv_c) begin
            for (int k = 0; k < int'(SEGS); k++) begin
                vld_q[k] <= vld_d[k];
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                sum_q[k] <= sum_d[k];
                cy_q[k]  <= cy_d[k];
            end
        end
    end

    assign out_valid = vld_q[SEGS-1];
    assign sum       = sum_q[SEGS-1];
    assign c_out     = cy_q[SEGS-1];

`ifdef PIPE_ADD_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Overflow is resolved alongside the last segment so it lines up with the final sum.
    assign ovf_d = (stg_a[SEGS-1][WIDTH-1] == stg_b[SEGS-1][WIDTH-1])
                && (sum_d[SEGS-1][WIDTH-1] != stg_a[SEGS-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv_c) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: doc/pipelined_adder_seg.md
# pipelined_adder_seg

Parametrised, segment-pipelined two's-complement adder/subtractor. Successor to the team's single-cycle 64-bit ripple adder. Splits a WIDTH-bit add into SEGS equal ripple segments, one per pipeline stage, with the carry registered between stages. Accepts one operation per clock behind a valid/ready handshake and sits between operand-fetch and writeback in the datapath.

## Interface
- WIDTH, 64, operand/result width; must be a multiple of SEGS.
- SEGS, 4, number of pipeline stages and segments; 1..WIDTH; segment width SW = WIDTH/SEGS.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  stage 0 can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  carry-out (add) / not-borrow (sub).
- ovf  out  1  signed overflow; present only with PIPE_ADD_OVF_EN.

## Operation
- Add: {c_out,sum} = a + b + c_in.
- Sub: {c_out,sum} = a + ~b + ~c_in, i.e. a − b − c_in; c_out=1 means no borrow.
- Inversion of b and c_in applied at input capture, before any segment.
- Stage k (0..SEGS−1) adds bits [k*SW +: SW] of a and b' plus the carry registered by stage k−1 (stage 0 uses effective carry-in); result bits and carry-out registered.
- Unconsumed upper operand segments travel alongside in skew registers; completed lower sum segments travel in deskew registers so all sum bits of one operation appear together.
- Per-stage valid bit; one global advance enable: adv = !out_valid || out_ready. When adv=1 every stage shifts by one; when adv=0 all stages, including data, hold.
- in_ready = adv. Transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
- Bubbles are not collapsed; they shift with the pipeline.
- Results emerge strictly in acceptance order; no reordering, no drops, no duplicates.
- Carry width: each segment adder is SW+1 bits; c_out is the carry from the last segment.

## Timing
- Latency: SEGS cycles from input transfer to out_valid with no stall; SEGS=1 gives registered single-cycle result.
- Throughput: one operation per cycle while out_ready=1.
- Reset (rst=1 at edge): all valid bits 0, sum=0, c_out=0, ovf=0; in_ready=1 in the cycle after reset. Reset mid-flight discards all in-flight operations; none emerge.
- in_ready is combinational from out_valid and out_ready only; no path from in_valid to in_ready.
- While out_valid=1 and out_ready=0: sum, c_out, ovf held stable; in_ready=0.
- Simultaneous output and input transfer in same cycle: allowed, full throughput.
- in_valid=0 with adv=1: a bubble enters stage 0.

## Configuration
- PIPE_ADD_OVF_EN defined: ovf port exists; ovf = (sign of a == sign of b') && (sign of sum != sign of a), aligned with sum, reset 0.
- Undefined: no ovf port, no overflow logic; all other behaviour identical.

## Test plan
- WIDTH=64, SEGS=4, add a=FFFF_FFFF_FFFF_FFFF, b=1, c_in=0 -> sum=0, c_out=1, out_valid exactly 4 cycles after transfer.
- Sub a=5, b=7, c_in=0 -> sum=FFFF_FFFF_FFFF_FFFE, c_out=0; then a=7, b=5 -> sum=2, c_out=1.
- 8 back-to-back random ops, out_ready=1 -> 8 results on 8 consecutive cycles, in order, matching reference model.
- out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 -> in_ready=0, sum/c_out stable, no loss; resumed stream complete and ordered.
- rst asserted with 3 ops in flight -> next cycle out_valid=0, sum=0, c_out=0; nothing emerges afterward.
- PIPE_ADD_OVF_EN defined: a=7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=8000_0000_0000_0000, ovf=1; a=8000_0000_0000_0000, b=1, sub -> ovf=1.
